serial_sum_deserializer: RTL

- Receive end of the bit-serial adder datapath.
- Collects the LSB-first sum stream produced by the serial adder into a parallel word.
- Presents the word on a valid/ready output handshake.
- Flags framing errors.
- Sits between the serial adder's `s` output and any word-wide consumer (register file, result FIFO).

---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_bit_counter.sv | 32 +++
 rtl/serial_sum_deserializer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and sizing for the serial sum deserializer and its bit counter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  localparam int MAX_WIDTH = 32;
  // Counts 0..N-1 where N can reach MAX_WIDTH+1 when the carry bit is collected.
  localparam int CNT_W = $clog2(MAX_WIDTH + 1);

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter: loads 1 on a start-of-frame bit, increments per accepted bit,
// flags the last position (N-1) so the FSM knows the word is complete.
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(N - 1));

endmodule

// File: rtl/serial_sum_deserializer.sv
// Collects the LSB-first serial adder sum into a parallel word with a valid/ready output.
// Define SERIAL_SUM_DESER_CARRY_EN to collect one extra flush bit as the final carry on cout.
module serial_sum_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  input  logic             out_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             cout,
  output logic             busy,
  output logic             err
);

`ifdef SERIAL_SUM_DESER_CARRY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif

  state_t           state, state_nxt;
  logic [N-1:0]     sreg, sreg_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             cnt_load, cnt_inc, cnt_clear;
  logic             start, capture, err_nxt;

  serial_bit_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clear = 1'b0;
    start     = 1'b0;
    capture   = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (bit_valid) begin
          if (sof) start = 1'b1;
          else     err_nxt = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (sof) begin
            start   = 1'b1;
            err_nxt = 1'b1;
          end else begin
            for (int i = 0; i < N; i++) begin
              if (cnt == CNT_W'(i)) sreg_nxt[i] = bit_in;
            end
            if (tc) begin
              capture   = 1'b1;
              cnt_clear = 1'b1;
              state_nxt = HOLD;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          // A sof bit on the transfer cycle chains straight into the next word.
          if (bit_valid && sof) begin
            start = 1'b1;
          end else begin
            state_nxt = IDLE;
            err_nxt   = bit_valid;
          end
        end else begin
          err_nxt = bit_valid;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start) begin
      sreg_nxt = N'(bit_in);
      if (N == 1) begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end else begin
        cnt_load  = 1'b1;
        state_nxt = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sreg       <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      word_valid <= (state_nxt == HOLD);
      busy       <= (state_nxt != IDLE);
      err        <= err_nxt;
      if (capture) word_out <= sreg_nxt[WIDTH-1:0];
    end
  end

`ifdef SERIAL_SUM_DESER_CARRY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cout <= 1'b0;
    else if (capture) cout <= sreg_nxt[N-1];
  end
`else
  assign cout = 1'b0;
`endif

endmodule
